// File: rtl/instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instr_decode_stage
//  Description : Registered RV32/RV64 instruction-decode pipeline stage.
//                Splits an instruction word into register indices, funct
//                fields, type class and sign-extended immediate, presented
//                one cycle later behind an optional two-entry skid buffer.
//                Tracks a saturating count of accepted illegal words.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_decode_stage #(
    parameter int XLEN        = 32,
    parameter int BRANCH_BIAS = 4,
    parameter int SKID        = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [2:0]      out_funct3,
    output logic            out_bit30,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_immed,
    output logic            out_illegal,
    output logic [15:0]     ill_count
);

    localparam logic [2:0] C_TY_ILL = 3'd0;
    localparam logic [2:0] C_TY_R   = 3'd1;
    localparam logic [2:0] C_TY_I   = 3'd2;
    localparam logic [2:0] C_TY_U   = 3'd3;
    localparam logic [2:0] C_TY_S   = 3'd4;
    localparam logic [2:0] C_TY_B   = 3'd5;
    localparam logic [2:0] C_TY_J   = 3'd6;
    localparam logic [2:0] C_TY_NOP = 3'd7;

    localparam logic [1:0] C_ST_EMPTY = 2'd0;
    localparam logic [1:0] C_ST_ONE   = 2'd1;
    localparam logic [1:0] C_ST_TWO   = 2'd2;

    localparam bit              C_RV64 = (XLEN == 64);
    localparam logic [XLEN-1:0] C_BIAS = XLEN'(BRANCH_BIAS);

    // One decoded entry as held in the output / skid registers.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic            bit30;
        logic [2:0]      typ;
        logic [XLEN-1:0] immed;
        logic            illegal;
    } entry_t;

    logic [2:0]      w_type;
    logic            w_shift;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm_ext;
    logic [XLEN-1:0] w_immed;
    entry_t          w_dec;
    entry_t          w_out;
    logic            w_accept;
    logic            w_drain;
    logic [15:0]     ill_count_q;

    // Classify the instruction by its major opcode.
    always_comb begin
        w_type = C_TY_ILL;
        if (in_instr[1:0] == 2'b11) begin
            case (in_instr[6:2])
                5'b01100:                   w_type = C_TY_R;
                5'b00000, 5'b00100, 5'b11001: w_type = C_TY_I;
                5'b01101, 5'b00101:         w_type = C_TY_U;
                5'b01000:                   w_type = C_TY_S;
                5'b11000:                   w_type = C_TY_B;
                5'b11011:                   w_type = C_TY_J;
                5'b00011, 5'b11100:         w_type = C_TY_NOP;
                5'b01110:                   w_type = C_RV64 ? C_TY_R : C_TY_ILL;
                5'b00110:                   w_type = C_RV64 ? C_TY_I : C_TY_ILL;
                default:                    w_type = C_TY_ILL;
            endcase
        end
    end

    // Shift-immediates (OP-IMM, and OP-IMM-32 on RV64) carry instr[30] as the
    // arithmetic/logical selector.
    assign w_shift = (((in_instr[6:0] & 7'b1011111) == 7'b0010011) ||
                      (C_RV64 && ((in_instr[6:0] & 7'b1011111) == 7'b0011011))) &&
                     (in_instr[13:12] == 2'b01);

    // Assemble the 32-bit immediate for the detected format.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            C_TY_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            C_TY_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            C_TY_U: w_imm32 = {in_instr[31:12], 12'd0};
            C_TY_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
            C_TY_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                               in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm32 = 32'd0;
        endcase
    end

    // Branch/jump offsets are rebased to the core's PC-after-fetch view.
    assign w_imm_ext = XLEN'($signed(w_imm32));
    assign w_immed   = ((w_type == C_TY_B) || (w_type == C_TY_J)) ? (w_imm_ext - C_BIAS)
                                                                   : w_imm_ext;

    // Build the full decoded entry; unused register fields read as zero.
    always_comb begin
        w_dec         = '0;
        w_dec.pc      = in_pc;
        w_dec.opcode  = in_instr[6:0];
        w_dec.typ     = w_type;
        w_dec.illegal = (w_type == C_TY_ILL);
        w_dec.immed   = w_immed;
        w_dec.funct3  = ((w_type == C_TY_U) || (w_type == C_TY_J)) ? 3'd0 : in_instr[14:12];
        if ((w_type == C_TY_R) || (w_type == C_TY_I) || (w_type == C_TY_U) || (w_type == C_TY_J))
            w_dec.rd = in_instr[11:7];
        if ((w_type == C_TY_R) || (w_type == C_TY_I) || (w_type == C_TY_S) || (w_type == C_TY_B))
            w_dec.rs1 = in_instr[19:15];
        if ((w_type == C_TY_R) || (w_type == C_TY_S) || (w_type == C_TY_B))
            w_dec.rs2 = in_instr[24:20];
        if ((w_type == C_TY_R) || ((w_type == C_TY_I) && w_shift))
            w_dec.bit30 = in_instr[30];
    end

    // Flush wins over both handshakes.
    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = out_valid && out_ready && !flush;

    generate
        if (SKID != 0) begin : g_skid
            logic [1:0] state_q;
            logic [1:0] state_d;
            logic       in_ready_q;
            logic       load_main;
            logic       load_skid;
            logic       skid_to_main;
            entry_t     main_q;
            entry_t     skid_q;

            // Occupancy FSM of the two-entry skid buffer.
            always_comb begin
                state_d      = state_q;
                load_main    = 1'b0;
                load_skid    = 1'b0;
                skid_to_main = 1'b0;
                if (flush) begin
                    state_d = C_ST_EMPTY;
                end else begin
                    case (state_q)
                        C_ST_EMPTY: begin
                            if (w_accept) begin
                                state_d   = C_ST_ONE;
                                load_main = 1'b1;
                            end
                        end
                        C_ST_ONE: begin
                            if (w_accept && w_drain) begin
                                load_main = 1'b1;
                            end else if (w_accept) begin
                                state_d   = C_ST_TWO;
                                load_skid = 1'b1;
                            end else if (w_drain) begin
                                state_d = C_ST_EMPTY;
                            end
                        end
                        C_ST_TWO: begin
                            if (w_drain) begin
                                state_d      = C_ST_ONE;
                                skid_to_main = 1'b1;
                            end
                        end
                        default: state_d = C_ST_EMPTY;
                    endcase
                end
            end

            // State, registered in_ready and the two entry registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q    <= C_ST_EMPTY;
                    in_ready_q <= 1'b1;
                    main_q     <= '0;
                    skid_q     <= '0;
                end else begin
                    state_q    <= state_d;
                    in_ready_q <= (state_d != C_ST_TWO);
                    if (load_main)
                        main_q <= w_dec;
                    else if (skid_to_main)
                        main_q <= skid_q;
                    if (load_skid)
                        skid_q <= w_dec;
                end
            end

            assign in_ready  = in_ready_q;
            assign out_valid = (state_q != C_ST_EMPTY);
            assign w_out     = main_q;
        end else begin : g_noskid
            logic   valid_q;
            entry_t main_q;

            // Single output register; refills in the same cycle it drains.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_q <= 1'b0;
                    main_q  <= '0;
                end else if (flush) begin
                    valid_q <= 1'b0;
                end else if (w_accept) begin
                    valid_q <= 1'b1;
                    main_q  <= w_dec;
                end else if (w_drain) begin
                    valid_q <= 1'b0;
                end
            end

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign w_out     = main_q;
        end
    endgenerate

    // Saturating count of accepted illegal words; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ill_count_q <= 16'd0;
        else if (w_accept && w_dec.illegal && (ill_count_q != 16'hFFFF))
            ill_count_q <= ill_count_q + 16'd1;
    end

    assign ill_count   = ill_count_q;
    assign out_pc      = w_out.pc;
    assign out_opcode  = w_out.opcode;
    assign out_rd      = w_out.rd;
    assign out_rs1     = w_out.rs1;
    assign out_rs2     = w_out.rs2;
    assign out_funct3  = w_out.funct3;
    assign out_bit30   = w_out.bit30;
    assign out_type    = w_out.typ;
    assign out_immed   = w_out.immed;
    assign out_illegal = w_out.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_decode_stage
//  Description : Scoreboard bench for instr_decode_stage. Instance A is
//                RV32 with skid buffer, instance B is RV64 without.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_decode_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic        b30;
        logic [2:0]  typ;
        logic [63:0] imm;
        logic        ill;
    } exp_t;

    localparam int BIAS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;

    logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic [31:0] a_in_instr = '0, a_in_pc = '0, a_out_pc, a_out_immed;
    logic [6:0]  a_out_opcode;
    logic [4:0]  a_out_rd, a_out_rs1, a_out_rs2;
    logic [2:0]  a_out_funct3, a_out_type;
    logic        a_out_bit30, a_out_illegal;
    logic [15:0] a_ill_count;

    logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    logic [31:0] b_in_instr = '0;
    logic [63:0] b_in_pc = '0, b_out_pc, b_out_immed;
    logic [6:0]  b_out_opcode;
    logic [4:0]  b_out_rd, b_out_rs1, b_out_rs2;
    logic [2:0]  b_out_funct3, b_out_type;
    logic        b_out_bit30, b_out_illegal;
    logic [15:0] b_ill_count;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    logic [15:0] cnt_a = '0, cnt_b = '0;
    bit   rand_a_on, rand_b_on;
    exp_t snap_a, snap_b;
    bit   hold_a = 0, hold_b = 0;

    always #5 clk = ~clk;

    instr_decode_stage #(.XLEN(32), .BRANCH_BIAS(BIAS), .SKID(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_opcode(a_out_opcode), .out_rd(a_out_rd), .out_rs1(a_out_rs1), .out_rs2(a_out_rs2),
        .out_funct3(a_out_funct3), .out_bit30(a_out_bit30), .out_type(a_out_type),
        .out_immed(a_out_immed), .out_illegal(a_out_illegal), .ill_count(a_ill_count)
    );

    instr_decode_stage #(.XLEN(64), .BRANCH_BIAS(BIAS), .SKID(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_opcode(b_out_opcode), .out_rd(b_out_rd), .out_rs1(b_out_rs1), .out_rs2(b_out_rs2),
        .out_funct3(b_out_funct3), .out_bit30(b_out_bit30), .out_type(b_out_type),
        .out_immed(b_out_immed), .out_illegal(b_out_illegal), .ill_count(b_ill_count)
    );

    // Reference decoder: format class from the opcode table, then fields by format.
    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc, input bit rv64);
        exp_t   e;
        longint off;
        e     = '0;
        off   = 0;
        e.op  = w[6:0];
        e.pc  = rv64 ? pc : {32'd0, pc[31:0]};
        if (w[1:0] != 2'b11) e.typ = 3'd0;
        else case (w[6:2])
            5'h0C:               e.typ = 3'd1;
            5'h00, 5'h04, 5'h19: e.typ = 3'd2;
            5'h0D, 5'h05:        e.typ = 3'd3;
            5'h08:               e.typ = 3'd4;
            5'h18:               e.typ = 3'd5;
            5'h1B:               e.typ = 3'd6;
            5'h03, 5'h1C:        e.typ = 3'd7;
            5'h0E:               e.typ = rv64 ? 3'd1 : 3'd0;
            5'h06:               e.typ = rv64 ? 3'd2 : 3'd0;
            default:             e.typ = 3'd0;
        endcase
        e.ill = (e.typ == 3'd0);
        e.f3  = w[14:12];
        case (e.typ)
            3'd1: begin e.rd = w[11:7]; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.b30 = w[30]; end
            3'd2: begin
                e.rd = w[11:7]; e.rs1 = w[19:15];
                off = longint'($signed(w[31:20]));
                if ((w[6:2] == 5'h04 || w[6:2] == 5'h06) && (w[14:12] == 3'd1 || w[14:12] == 3'd5))
                    e.b30 = w[30];
            end
            3'd3: begin e.rd = w[11:7]; e.f3 = 3'd0; off = longint'($signed({w[31:12], 12'd0})); end
            3'd4: begin e.rs1 = w[19:15]; e.rs2 = w[24:20]; off = longint'($signed({w[31:25], w[11:7]})); end
            3'd5: begin
                e.rs1 = w[19:15]; e.rs2 = w[24:20];
                off = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0})) - BIAS;
            end
            3'd6: begin
                e.rd = w[11:7]; e.f3 = 3'd0;
                off = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})) - BIAS;
            end
            default: off = 0;
        endcase
        e.imm = rv64 ? 64'(off) : {32'd0, off[31:0]};
        return e;
    endfunction

    function automatic exp_t act_a();
        exp_t e;
        e = '{pc: {32'd0, a_out_pc}, op: a_out_opcode, rd: a_out_rd, rs1: a_out_rs1, rs2: a_out_rs2,
              f3: a_out_funct3, b30: a_out_bit30, typ: a_out_type, imm: {32'd0, a_out_immed},
              ill: a_out_illegal};
        return e;
    endfunction

    function automatic exp_t act_b();
        exp_t e;
        e = '{pc: b_out_pc, op: b_out_opcode, rd: b_out_rd, rs1: b_out_rs1, rs2: b_out_rs2,
              f3: b_out_funct3, b30: b_out_bit30, typ: b_out_type, imm: b_out_immed,
              ill: b_out_illegal};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 15))
            0: w[6:2] = 5'h00;  1: w[6:2] = 5'h04;  2: w[6:2] = 5'h19;  3: w[6:2] = 5'h0C;
            4: w[6:2] = 5'h0D;  5: w[6:2] = 5'h05;  6: w[6:2] = 5'h08;  7: w[6:2] = 5'h18;
            8: w[6:2] = 5'h1B;  9: w[6:2] = 5'h03; 10: w[6:2] = 5'h1C; 11: w[6:2] = 5'h0E;
           12: w[6:2] = 5'h06; 13: w[6:2] = 5'h1F; 14: w[6:2] = 5'h0A;
           default: ;
        endcase
        w[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom()) : 2'b11;
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record the expected decode of a word the DUT is accepting on the coming edge.
    task automatic push_exp(input int d, input logic [31:0] w, input logic [63:0] pc);
        exp_t e;
        e = model(w, pc, d == 1);
        if (d == 0) begin
            q_a.push_back(e);
            if (e.ill && cnt_a != 16'hFFFF) cnt_a++;
        end else begin
            q_b.push_back(e);
            if (e.ill && cnt_b != 16'hFFFF) cnt_b++;
        end
    endtask

    // Offer one word; returns #1 after the edge that accepted it.
    task automatic send(input int d, input logic [31:0] w, input logic [63:0] pc);
        bit done;
        done = 0;
        if (d == 0) begin a_in_valid = 1; a_in_instr = w; a_in_pc = pc[31:0]; end
        else        begin b_in_valid = 1; b_in_instr = w; b_in_pc = pc; end
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            if (((d == 0) ? a_in_ready : b_in_ready) && !flush) begin
                push_exp(d, w, pc);
                done = 1;
            end
            @(posedge clk); #1;
        end
        if (d == 0) a_in_valid = 0; else b_in_valid = 0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: dut %0d word %h not accepted in 200 cycles", d, w);
        end
    endtask

    task automatic drain(input int d);
        if (d == 0) a_out_ready = 1; else b_out_ready = 1;
        for (int t = 0; t < 100; t++) begin
            if (((d == 0) ? q_a.size() : q_b.size()) == 0) break;
            @(posedge clk); #1;
        end
        chk($sformatf("drain_dut%0d_left", d), 64'((d == 0) ? q_a.size() : q_b.size()), 64'd0);
    endtask

    // Monitor A: pop and compare on every completed output handshake.
    always @(negedge clk) begin
        exp_t act, e;
        act = act_a();
        if (!rst_n) hold_a = 0;
        else if (flush) begin q_a.delete(); hold_a = 0; end
        else if (a_out_valid && a_out_ready) begin
            n_cmp++;
            if (q_a.size() == 0) begin
                n_bad++; $display("FAIL out_a_unexpected: got %h expected nothing", act);
            end else begin
                e = q_a.pop_front();
                if (act !== e) begin n_bad++; $display("FAIL out_a: got %h expected %h", act, e); end
            end
            hold_a = 0;
        end else if (a_out_valid) begin
            if (hold_a) begin
                n_cmp++;
                if (act !== snap_a) begin n_bad++; $display("FAIL stall_a: got %h expected %h", act, snap_a); end
            end
            snap_a = act; hold_a = 1;
        end else hold_a = 0;
    end

    // Monitor B: same scheme for the RV64 instance.
    always @(negedge clk) begin
        exp_t act, e;
        act = act_b();
        if (!rst_n) hold_b = 0;
        else if (flush) begin q_b.delete(); hold_b = 0; end
        else if (b_out_valid && b_out_ready) begin
            n_cmp++;
            if (q_b.size() == 0) begin
                n_bad++; $display("FAIL out_b_unexpected: got %h expected nothing", act);
            end else begin
                e = q_b.pop_front();
                if (act !== e) begin n_bad++; $display("FAIL out_b: got %h expected %h", act, e); end
            end
            hold_b = 0;
        end else if (b_out_valid) begin
            if (hold_b) begin
                n_cmp++;
                if (act !== snap_b) begin n_bad++; $display("FAIL stall_b: got %h expected %h", act, snap_b); end
            end
            snap_b = act; hold_b = 1;
        end else hold_b = 0;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2 rst_n = 0;
        #10;
        chk("rst_a_valid", 64'(a_out_valid), 64'd0);
        chk("rst_a_type", 64'(a_out_type), 64'd0);
        chk("rst_a_illegal", 64'(a_out_illegal), 64'd0);
        chk("rst_a_immed", 64'(a_out_immed), 64'd0);
        chk("rst_a_count", 64'(a_ill_count), 64'd0);
        chk("rst_b_valid", 64'(b_out_valid), 64'd0);
        chk("rst_b_pc", b_out_pc, 64'd0);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("rel_a_in_ready", 64'(a_in_ready), 64'd1);
        chk("rel_b_in_ready", 64'(b_in_ready), 64'd1);

        // Directed decodes on the RV32 instance.
        a_out_ready = 1;
        send(0, 32'hFFF10093, 64'h100);
        chk("addi_valid", 64'(a_out_valid), 64'd1);
        chk("addi_type", 64'(a_out_type), 64'd2);
        chk("addi_rd", 64'(a_out_rd), 64'd1);
        chk("addi_rs1", 64'(a_out_rs1), 64'd2);
        chk("addi_rs2", 64'(a_out_rs2), 64'd0);
        chk("addi_immed", 64'(a_out_immed), 64'hFFFFFFFF);
        chk("addi_illegal", 64'(a_out_illegal), 64'd0);
        send(0, 32'h00000463, 64'h104);
        chk("beq_type", 64'(a_out_type), 64'd5);
        chk("beq_immed", 64'(a_out_immed), 64'h4);
        send(0, 32'hFFDFF0EF, 64'h108);
        chk("jal_type", 64'(a_out_type), 64'd6);
        chk("jal_rd", 64'(a_out_rd), 64'd1);
        chk("jal_immed", 64'(a_out_immed), 64'hFFFFFFF8);
        send(0, 32'h00000000, 64'h10C);
        send(0, 32'hFFFFFFFF, 64'h110);
        chk("ill_type", 64'(a_out_type), 64'd0);
        chk("ill_flag", 64'(a_out_illegal), 64'd1);
        chk("ill_count_2", 64'(a_ill_count), 64'd2);
        send(0, 32'hFFF1009B, 64'h114);
        chk("addiw_rv32_type", 64'(a_out_type), 64'd0);
        repeat (2) begin @(posedge clk); #1; end

        // Skid fill: two words accepted with out_ready low, third stalls.
        a_out_ready = 0;
        a_in_valid = 1; a_in_instr = 32'h00500113; a_in_pc = 32'h200;
        @(negedge clk); chk("skid_rdy1", 64'(a_in_ready), 64'd1); push_exp(0, a_in_instr, 64'h200);
        @(posedge clk); #1; a_in_instr = 32'h002081B3; a_in_pc = 32'h204;
        @(negedge clk); chk("skid_rdy2", 64'(a_in_ready), 64'd1); push_exp(0, a_in_instr, 64'h204);
        @(posedge clk); #1; a_in_instr = 32'h00312023; a_in_pc = 32'h208;
        @(negedge clk); chk("skid_rdy3_low", 64'(a_in_ready), 64'd0);
        @(posedge clk); #1; a_out_ready = 1;
        send(0, 32'h00312023, 64'h208);
        chk("skid_third_pc", 64'(a_out_pc), 64'h208);
        drain(0);

        // Flush while full with a word on offer.
        a_out_ready = 0;
        send(0, 32'h00A00093, 64'h300);
        send(0, 32'h00B00093, 64'h304);
        chk("flush_pre_rdy", 64'(a_in_ready), 64'd0);
        a_in_valid = 1; a_in_instr = 32'h0; flush = 1;
        @(posedge clk); #1; flush = 0; a_in_valid = 0;
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_rdy", 64'(a_in_ready), 64'd1);
        chk("flush_count", 64'(a_ill_count), 64'(cnt_a));
        a_out_ready = 1;

        // Random traffic on both instances with random backpressure.
        rand_a_on = 1; rand_b_on = 1;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send(0, rand_instr(), {32'd0, $urandom()});
                end
                rand_a_on = 0;
            end
            begin
                while (rand_a_on) begin @(posedge clk); #1; a_out_ready = ($urandom_range(0, 3) != 0); end
            end
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    send(1, rand_instr(), {$urandom(), $urandom()});
                end
                rand_b_on = 0;
            end
            begin
                while (rand_b_on) begin @(posedge clk); #1; b_out_ready = ($urandom_range(0, 3) != 0); end
            end
        join
        drain(0);
        drain(1);
        chk("rand_a_count", 64'(a_ill_count), 64'(cnt_a));
        chk("rand_b_count", 64'(b_ill_count), 64'(cnt_b));

        // RV64 word-width immediate decode.
        send(1, 32'hFFF1009B, 64'h8000_0000_0000_1000);
        chk("addiw_rv64_type", 64'(b_out_type), 64'd2);
        chk("addiw_rv64_immed", b_out_immed, 64'hFFFFFFFFFFFFFFFF);
        chk("addiw_rv64_pc", b_out_pc, 64'h8000_0000_0000_1000);
        drain(1);

        // Asynchronous reset in the middle of a held stream.
        a_out_ready = 0;
        send(0, 32'h00000000, 64'h400);
        send(0, 32'hFFF10093, 64'h404);
        #3 rst_n = 0;
        #1;
        chk("mrst_a_valid", 64'(a_out_valid), 64'd0);
        chk("mrst_a_pc", 64'(a_out_pc), 64'd0);
        chk("mrst_a_immed", 64'(a_out_immed), 64'd0);
        chk("mrst_a_type", 64'(a_out_type), 64'd0);
        chk("mrst_a_rd", 64'(a_out_rd), 64'd0);
        chk("mrst_a_illegal", 64'(a_out_illegal), 64'd0);
        chk("mrst_a_count", 64'(a_ill_count), 64'd0);
        chk("mrst_b_count", 64'(b_ill_count), 64'd0);
        q_a.delete(); q_b.delete(); cnt_a = 0; cnt_b = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        chk("mrst_rel_rdy", 64'(a_in_ready), 64'd1);
        a_out_ready = 1;

        // Saturation of the illegal counter.
        b_out_ready = 1;
        for (int i = 0; i < 65537; i++) send(1, 32'h0, 64'(i));
        chk("sat_count", 64'(b_ill_count), 64'hFFFF);
        chk("sat_model", 64'(b_ill_count), 64'(cnt_b));
        drain(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
